// File: rtl/mux16_rr_sched.sv
// Round-robin owner of a shared 16:1 single-bit mux.
// Grants one requester at a time for at most HOLD_MAX cycles, drives the mux
// select and samples the mux output, tagging each sample with its channel.
module mux16_rr_sched #(
  parameter int N_CH     = 16,
  parameter int HOLD_MAX = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic [N_CH-1:0] req,
  input  logic            mux_y,
  output logic [3:0]      sel,
  output logic [N_CH-1:0] grant,
  output logic            busy,
  output logic            sample_valid,
  output logic            sample_data,
  output logic [3:0]      sample_ch
);

  typedef enum logic {IDLE, GRANT} state_t;

  // Last hold count value before a forced release.
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  state_t            state_q, state_d;
  logic [3:0]        ptr_q, ptr_d;
  logic [7:0]        hold_cnt_q, hold_cnt_d;
  logic [3:0]        sel_q, sel_d;
  logic [N_CH-1:0]   grant_q, grant_d;
  logic              busy_q, busy_d;
  logic              svld_q, svld_d;
  logic              sdata_q, sdata_d;
  logic [3:0]        sch_q, sch_d;

  logic [3:0]        search_base;
  logic [3:0]        win_idx;
  logic              win_found;
  logic              release_w;
  logic              launch;

  // Rotating priority search: on release the search starts just past the
  // outgoing owner, so the owner itself ends up with lowest priority.
  always_comb begin
    logic [3:0] idx;
    search_base = (state_q == GRANT) ? (sel_q + 4'd1) : ptr_q;
    win_found   = 1'b0;
    win_idx     = search_base;
    idx         = search_base;
    for (int i = N_CH - 1; i >= 0; i--) begin
      idx = search_base + i[3:0];
      if (req[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  // Grant bookkeeping: release, launch and all next-state values.
  always_comb begin
    release_w  = !req[sel_q] || (hold_cnt_q == HOLD_LAST);
    launch     = en && win_found;
    state_d    = state_q;
    ptr_d      = ptr_q;
    hold_cnt_d = hold_cnt_q;
    sel_d      = sel_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    svld_d     = svld_q;
    sdata_d    = sdata_q;
    sch_d      = sch_q;
    case (state_q)
      IDLE: begin
        svld_d  = 1'b0;
        grant_d = '0;
        busy_d  = 1'b0;
        if (launch) begin
          state_d    = GRANT;
          sel_d      = win_idx;
          grant_d    = N_CH'(1) << win_idx;
          busy_d     = 1'b1;
          hold_cnt_d = 8'd0;
        end
      end
      GRANT: begin
        // sel is registered, so mux_y already reflects the current owner.
        svld_d  = 1'b1;
        sdata_d = mux_y;
        sch_d   = sel_q;
        if (release_w) begin
          ptr_d      = sel_q + 4'd1;
          hold_cnt_d = 8'd0;
          if (launch) begin
            sel_d   = win_idx;
            grant_d = N_CH'(1) << win_idx;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            busy_d  = 1'b0;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; an asynchronous reset abandons any grant and sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= 4'd0;
      hold_cnt_q <= 8'd0;
      sel_q      <= 4'd0;
      grant_q    <= '0;
      busy_q     <= 1'b0;
      svld_q     <= 1'b0;
      sdata_q    <= 1'b0;
      sch_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      hold_cnt_q <= hold_cnt_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      busy_q     <= busy_d;
      svld_q     <= svld_d;
      sdata_q    <= sdata_d;
      sch_q      <= sch_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    sel          = sel_q;
    grant        = grant_q;
    busy         = busy_q;
    sample_valid = svld_q;
    sample_data  = sdata_q;
    sample_ch    = sch_q;
  end

endmodule

// File: tb/tb_mux16_rr_sched.sv
// Directed bench for mux16_rr_sched: three instances share clock, reset,
// enable and requests, with hold limits of 8, 2 and 1.
module tb_mux16_rr_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] req = '0;

  logic [15:0] mux_in_a = '0;
  logic [15:0] mux_in_b = '0;
  logic [15:0] mux_in_c = '0;
  logic        mux_y_a, mux_y_b, mux_y_c;

  logic [3:0]  sel_a, sel_b, sel_c;
  logic [15:0] grant_a, grant_b, grant_c;
  logic        busy_a, busy_b, busy_c;
  logic        sv_a, sv_b, sv_c;
  logic        sd_a, sd_b, sd_c;
  logic [3:0]  sch_a, sch_b, sch_c;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign mux_y_a = mux_in_a[sel_a];
  assign mux_y_b = mux_in_b[sel_b];
  assign mux_y_c = mux_in_c[sel_c];

  mux16_rr_sched #(.N_CH(16), .HOLD_MAX(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mux_y(mux_y_a),
    .sel(sel_a), .grant(grant_a), .busy(busy_a), .sample_valid(sv_a),
    .sample_data(sd_a), .sample_ch(sch_a));

  mux16_rr_sched #(.N_CH(16), .HOLD_MAX(2)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mux_y(mux_y_b),
    .sel(sel_b), .grant(grant_b), .busy(busy_b), .sample_valid(sv_b),
    .sample_data(sd_b), .sample_ch(sch_b));

  mux16_rr_sched #(.N_CH(16), .HOLD_MAX(1)) u_dut_c (
    .clk(clk), .rst_n(rst_n), .en(en), .req(req), .mux_y(mux_y_c),
    .sel(sel_c), .grant(grant_c), .busy(busy_c), .sample_valid(sv_c),
    .sample_data(sd_c), .sample_ch(sch_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b0;
    req   = '0;
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    rst_n = 1'b0;
    en    = 1'b1;
    req   = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if ({sel_a, grant_a, busy_a, sv_a, sd_a, sch_a} !== 27'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: got sel=%0d grant=%h busy=%b sv=%b sd=%b ch=%0d, want all 0",
                 k, sel_a, grant_a, busy_a, sv_a, sd_a, sch_a);
      end
    end
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      n_cmp++;
      if ({sel_a, grant_a, busy_a, sv_a, sd_a, sch_a} !== 27'd0) begin
        n_fail++;
        $display("FAIL idle_noreq cyc%0d: got sel=%0d grant=%h busy=%b sv=%b sd=%b ch=%0d, want all 0",
                 k, sel_a, grant_a, busy_a, sv_a, sd_a, sch_a);
      end
    end
  endtask

  task automatic test_single();
    do_reset();
    en       = 1'b1;
    req      = 16'h0020;
    mux_in_a = 16'h0020;
    step();  // grant appears
    n_cmp++;
    if (grant_a !== 16'h0020 || sel_a !== 4'd5 || busy_a !== 1'b1 || sv_a !== 1'b0) begin
      n_fail++;
      $display("FAIL single_grant: got grant=%h sel=%0d busy=%b sv=%b, want 0020 5 1 0",
               grant_a, sel_a, busy_a, sv_a);
    end
    step();  // first sample = 1
    n_cmp++;
    if (sv_a !== 1'b1 || sd_a !== 1'b1 || sch_a !== 4'd5) begin
      n_fail++;
      $display("FAIL single_s0: got sv=%b sd=%b ch=%0d, want 1 1 5", sv_a, sd_a, sch_a);
    end
    mux_in_a = 16'h0000;
    step();  // second sample = 0
    n_cmp++;
    if (sv_a !== 1'b1 || sd_a !== 1'b0 || sch_a !== 4'd5 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL single_s1: got sv=%b sd=%b ch=%0d busy=%b, want 1 0 5 1", sv_a, sd_a, sch_a, busy_a);
    end
    mux_in_a = 16'h0020;
    req      = 16'h0000;
    step();  // owner dropped: release, last sample = 1
    n_cmp++;
    if (sv_a !== 1'b1 || sd_a !== 1'b1 || sch_a !== 4'd5 || busy_a !== 1'b0 || grant_a !== 16'h0) begin
      n_fail++;
      $display("FAIL single_s2: got sv=%b sd=%b ch=%0d busy=%b grant=%h, want 1 1 5 0 0000",
               sv_a, sd_a, sch_a, busy_a, grant_a);
    end
    step();  // sample_valid falls one cycle after busy
    n_cmp++;
    if (sv_a !== 1'b0 || busy_a !== 1'b0 || sel_a !== 4'd5) begin
      n_fail++;
      $display("FAIL single_tail: got sv=%b busy=%b sel=%0d, want 0 0 5", sv_a, busy_a, sel_a);
    end
  endtask

  task automatic test_hold_timeout();
    logic [15:0] exp_g;
    do_reset();
    en  = 1'b1;
    req = 16'h0008;
    for (int k = 0; k < 20; k++) begin
      step();
      n_cmp++;
      if (grant_a !== 16'h0008 || busy_a !== 1'b1) begin
        n_fail++;
        $display("FAIL hold_self cyc%0d: got grant=%h busy=%b, want 0008 1", k, grant_a, busy_a);
      end
    end
    do_reset();
    en  = 1'b1;
    req = 16'h0018;
    for (int k = 0; k < 24; k++) begin
      step();
      exp_g = (k < 8) ? 16'h0008 : (k < 16) ? 16'h0010 : 16'h0008;
      n_cmp++;
      if (grant_a !== exp_g) begin
        n_fail++;
        $display("FAIL hold_rotate cyc%0d: got grant=%h, want %h", k, grant_a, exp_g);
      end
    end
  endtask

  task automatic test_rr_wrap();
    logic [15:0] exp_g;
    logic [3:0]  exp_s;
    do_reset();
    en  = 1'b1;
    req = 16'h8001;
    for (int k = 0; k < 8; k++) begin
      step();
      exp_s = ((k % 4) < 2) ? 4'd0 : 4'd15;
      exp_g = ((k % 4) < 2) ? 16'h0001 : 16'h8000;
      n_cmp++;
      if (grant_b !== exp_g || sel_b !== exp_s || busy_b !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_wrap_h2 cyc%0d: got grant=%h sel=%0d busy=%b, want %h %0d 1",
                 k, grant_b, sel_b, busy_b, exp_g, exp_s);
      end
    end
    do_reset();
    en  = 1'b1;
    req = 16'h0011;
    for (int k = 0; k < 6; k++) begin
      step();
      exp_g = (k % 2 == 0) ? 16'h0001 : 16'h0010;
      n_cmp++;
      if (grant_c !== exp_g || busy_c !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_h1 cyc%0d: got grant=%h busy=%b, want %h 1", k, grant_c, busy_c, exp_g);
      end
    end
  endtask

  task automatic test_enable_gating();
    do_reset();
    en  = 1'b1;
    req = 16'h0080;
    step();
    n_cmp++;
    if (grant_a !== 16'h0080) begin
      n_fail++;
      $display("FAIL en_first: got grant=%h, want 0080", grant_a);
    end
    en  = 1'b0;
    req = 16'h0081;
    for (int k = 1; k < 8; k++) begin
      step();
      n_cmp++;
      if (grant_a !== 16'h0080 || busy_a !== 1'b1) begin
        n_fail++;
        $display("FAIL en_hold cyc%0d: got grant=%h busy=%b, want 0080 1", k, grant_a, busy_a);
      end
    end
    for (int k = 0; k < 3; k++) begin
      step();
      n_cmp++;
      if (grant_a !== 16'h0000 || busy_a !== 1'b0) begin
        n_fail++;
        $display("FAIL en_idle cyc%0d: got grant=%h busy=%b, want 0000 0", k, grant_a, busy_a);
      end
    end
    en = 1'b1;
    step();
    n_cmp++;
    if (grant_a !== 16'h0001 || sel_a !== 4'd0 || busy_a !== 1'b1) begin
      n_fail++;
      $display("FAIL en_resume: got grant=%h sel=%0d busy=%b, want 0001 0 1", grant_a, sel_a, busy_a);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en  = 1'b1;
    req = 16'h0200;
    step();
    step();
    n_cmp++;
    if (grant_a !== 16'h0200 || sv_a !== 1'b1 || sch_a !== 4'd9) begin
      n_fail++;
      $display("FAIL areset_pre: got grant=%h sv=%b ch=%0d, want 0200 1 9", grant_a, sv_a, sch_a);
    end
    #3;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({grant_a, sel_a, busy_a, sv_a} !== 22'd0) begin
      n_fail++;
      $display("FAIL areset_clear: got grant=%h sel=%0d busy=%b sv=%b, want all 0",
               grant_a, sel_a, busy_a, sv_a);
    end
    req = 16'h0204;
    #1;
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (grant_a !== 16'h0004 || sel_a !== 4'd2) begin
      n_fail++;
      $display("FAIL areset_after: got grant=%h sel=%0d, want 0004 2", grant_a, sel_a);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_hold_timeout();
    test_rr_wrap();
    test_enable_gating();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
